spi_burst_slave: RTL

//  Gen-2 SPI slave front end for the on-chip RAM. It owns the write and read address registers and drives a

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_miso_shifter.sv | 42 ++++
 rtl/spi_burst_slave.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the burst-capable SPI RAM slave.
//   cmd_e    : 2-bit command decoded from the first bits of a frame
//   state_e  : controller state encoding
//   CMD_BITS : number of command bits at the start of a frame
package spi_pkg;

    localparam int unsigned CMD_BITS = 2;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_SHIFT = 3'd4
    } state_e;

endpackage

// File: rtl/spi_miso_shifter.sv
// MSB-first parallel-in / serial-out shift register for read data.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load_i     : capture data_i and restart the bit count
//   shift_i    : advance to the next bit
//   data_i     : parallel word (WIDTH bits)
//   bit_o      : current serial bit (MSB of the register)
//   done_o     : high while the last bit of the word is presented
module spi_miso_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o,
    output logic             done_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            sh_q  <= data_i;
            cnt_q <= '0;
        end else if (shift_i) begin
            sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bit_o  = sh_q[WIDTH-1];
    assign done_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/spi_burst_slave.sv
// SPI slave front end for the on-chip single-port RAM, with burst transfers.
// Frame: 2 command bits then PAYLOAD_BITS bits, MSB first, sampled on posedge clk.
// Ports:
//   clk, rst_n             : system/SPI bit clock, async active-low reset
//   SS_N, MOSI, MISO       : SPI pins (slave select active low)
//   mem_addr/wdata/we/re   : memory request port (we/re are one-cycle strobes)
//   mem_rdata, mem_rvalid  : memory read response
//   busy                   : high whenever the controller is not idle
module spi_burst_slave
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned AUTO_INC   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_N,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  busy
);

    localparam int unsigned PAYLOAD_BITS = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
    localparam int unsigned CNT_W        = $clog2(PAYLOAD_BITS + 1);
    localparam logic [CNT_W-1:0]     CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0]     PAY_LAST  = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (AUTO_INC == 0) return a;
        if (a == LAST_ADDR) return '0;
        return a + ADDR_SIZE'(1);
    endfunction

    state_e                  state_q, state_d;
    cmd_e                    cmd_q, cmd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    // Holds the bits received so far; the final bit comes straight from MOSI.
    logic [PAYLOAD_BITS-2:0] pay_q, pay_d;
    logic [PAYLOAD_BITS-1:0] pay_next;
    logic [ADDR_SIZE-1:0]    wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]    rd_addr_q, rd_addr_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic                    re_q, re_d;

    logic sh_load, sh_shift, sh_bit, sh_done;

    spi_miso_shifter #(
        .WIDTH(DATA_WIDTH)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (sh_load),
        .shift_i(sh_shift),
        .data_i (mem_rdata),
        .bit_o  (sh_bit),
        .done_o (sh_done)
    );

    assign pay_next = {pay_q, MOSI};

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        pay_d     = pay_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;

        if (SS_N) begin
            // Deselect discards any partial frame; address registers are kept.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
                ST_CMD: begin
                    cmd_d = cmd_e'({cmd_q[0], MOSI});
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CMD_LAST) begin
                        cnt_d = '0;
                        if (cmd_d == RD_DATA) begin
                            state_d = ST_RD_WAIT;
                            re_d    = 1'b1;
                            addr_d  = rd_addr_q;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    pay_d = pay_next[PAYLOAD_BITS-2:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == PAY_LAST) begin
                        cnt_d = '0;
                        case (cmd_q)
                            WR_ADDR: begin
                                wr_addr_d = pay_next[ADDR_SIZE-1:0];
                                state_d   = ST_CMD;
                            end
                            RD_ADDR: begin
                                rd_addr_d = pay_next[ADDR_SIZE-1:0];
                                state_d   = ST_CMD;
                            end
                            default: begin
                                // Strobe is issued next cycle from the current
                                // address; advancing wr_addr now is equivalent to
                                // advancing it after the strobe.
                                wdata_d   = pay_next[DATA_WIDTH-1:0];
                                addr_d    = wr_addr_q;
                                we_d      = 1'b1;
                                wr_addr_d = next_addr(wr_addr_q);
                            end
                        endcase
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid) begin
                        sh_load = 1'b1;
                        state_d = ST_RD_SHIFT;
                    end
                end
                ST_RD_SHIFT: begin
                    if (sh_done) begin
                        rd_addr_d = next_addr(rd_addr_q);
                        addr_d    = rd_addr_d;
                        re_d      = 1'b1;
                        state_d   = ST_RD_WAIT;
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= WR_ADDR;
            cnt_q     <= '0;
            pay_q     <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            pay_q     <= pay_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign busy      = (state_q != ST_IDLE);
    assign MISO      = (state_q == ST_RD_SHIFT) & sh_bit;

endmodule
